// File: rtl/atu_pkg.sv
// Shared types, defaults and quadrature decode helper for the angle tracking unit.
package atu_pkg;

  localparam int unsigned COUNTS_PER_REV_DEF = 1006;
  localparam int unsigned ANGLE_W_DEF        = 12;
  localparam int unsigned FILTER_LEN_DEF     = 4;

  typedef enum logic {ATU_INIT, ATU_TRACK} atu_state_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR} step_t;

  // Increment direction follows AB Gray order 00 -> 10 -> 11 -> 01 -> 00.
  function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] ab);
    logic [1:0] fwd;
    case (prev_ab)
      2'b00:   fwd = 2'b10;
      2'b10:   fwd = 2'b11;
      2'b11:   fwd = 2'b01;
      default: fwd = 2'b00;
    endcase
    if (ab == prev_ab) begin
      return STEP_NONE;
    end else if ((ab ^ prev_ab) == 2'b11) begin
      return STEP_ERR;
    end else if (ab == fwd) begin
      return STEP_INC;
    end else begin
      return STEP_DEC;
    end
  endfunction

endpackage

// File: rtl/atu_input_filter.sv
// Two-flop synchroniser plus glitch filter for one encoder line; stable flags a settled level.
module atu_input_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic raw,
  output logic level,
  output logic stable
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] stab_q, stab_d;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      stab_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    stab_d  = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Stability also looks at the first sync stage so an edge still in flight blocks it.
    if ((sync1_q == sync2_q) && (sync2_q == level_q)) begin
      stab_d = (stab_q == CntW'(FILTER_LEN)) ? stab_q : stab_q + 1'b1;
    end
  end

  assign level  = level_q;
  assign stable = (stab_q == CntW'(FILTER_LEN));

endmodule

// File: rtl/angle_tracking_unit.sv
// Quadrature encoder decoder producing a wrap-around shaft angle.
// Optional index input enabled by defining ATU_INDEX_EN.
module angle_tracking_unit
  import atu_pkg::*;
#(
  parameter int unsigned COUNTS_PER_REV = COUNTS_PER_REV_DEF,
  parameter int unsigned ANGLE_W        = ANGLE_W_DEF,
  parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               enc_a,
  input  logic               enc_b,
`ifdef ATU_INDEX_EN
  input  logic               enc_i,
  output logic               index_seen,
`endif
  input  logic               atu_reset,
  input  logic               atu_monitor,
  output logic [ANGLE_W-1:0] current_angle,
  output logic               direction,
  output logic               step_error,
  output logic               tracking
);

  localparam logic [ANGLE_W-1:0] MaxAngle = ANGLE_W'(COUNTS_PER_REV - 1);

  logic a_level, a_stable, b_level, b_stable;
  logic [1:0] ab;

  atu_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk    (clk),
    .n_reset(n_reset),
    .raw    (enc_a),
    .level  (a_level),
    .stable (a_stable)
  );

  atu_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk    (clk),
    .n_reset(n_reset),
    .raw    (enc_b),
    .level  (b_level),
    .stable (b_stable)
  );

  assign ab = {a_level, b_level};

  atu_state_t         state_q, state_d;
  logic [1:0]         prev_ab_q, prev_ab_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               dir_q, dir_d;
  logic               err_q, err_d;
  logic               index_rise;
  logic               idx_seen_q, idx_seen_d;
  step_t              step;

`ifdef ATU_INDEX_EN
  logic i_level, i_stable, i_prev_q;

  atu_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (
    .clk    (clk),
    .n_reset(n_reset),
    .raw    (enc_i),
    .level  (i_level),
    .stable (i_stable)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      i_prev_q <= 1'b0;
    end else begin
      i_prev_q <= i_level;
    end
  end

  assign index_rise = i_level & ~i_prev_q;
  assign index_seen = idx_seen_q;
`else
  assign index_rise = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ATU_INIT;
      prev_ab_q  <= 2'b00;
      angle_q    <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      idx_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_ab_q  <= prev_ab_d;
      angle_q    <= angle_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      idx_seen_q <= idx_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_ab_d  = prev_ab_q;
    angle_d    = angle_q;
    dir_d      = dir_q;
    err_d      = err_q;
    idx_seen_d = idx_seen_q;
    step       = decode_step(prev_ab_q, ab);
    unique case (state_q)
      ATU_INIT: begin
        if (a_stable && b_stable) begin
          prev_ab_d = ab;
          state_d   = ATU_TRACK;
        end
      end
      ATU_TRACK: begin
        prev_ab_d = ab;
        if (step == STEP_ERR) begin
          err_d = 1'b1;
        end
        if (index_rise) begin
          angle_d    = '0;
          idx_seen_d = 1'b1;
        end else if (atu_monitor && (step == STEP_INC)) begin
          angle_d = (angle_q == MaxAngle) ? '0 : angle_q + 1'b1;
          dir_d   = 1'b1;
        end else if (atu_monitor && (step == STEP_DEC)) begin
          angle_d = (angle_q == '0) ? MaxAngle : angle_q - 1'b1;
          dir_d   = 1'b0;
        end
      end
      default: state_d = ATU_INIT;
    endcase
    // Synchronous clear overrides everything and resyncs prev_ab so release never counts.
    if (!atu_reset) begin
      angle_d    = '0;
      err_d      = 1'b0;
      dir_d      = 1'b0;
      idx_seen_d = 1'b0;
      prev_ab_d  = ab;
    end
  end

  assign current_angle = angle_q;
  assign direction     = dir_q;
  assign step_error    = err_q;
  assign tracking      = (state_q == ATU_TRACK);

endmodule

// File: tb/tb_angle_tracking_unit.sv
// Directed table-driven bench for angle_tracking_unit (default parameters).
module tb_angle_tracking_unit;

  logic        clk = 1'b0;
  logic        n_reset, enc_a, enc_b, atu_reset, atu_monitor;
  logic [11:0] current_angle;
  logic        direction, step_error, tracking;
`ifdef ATU_INDEX_EN
  logic        enc_i, index_seen;
`endif

  angle_tracking_unit dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
`ifdef ATU_INDEX_EN
    .enc_i        (enc_i),
    .index_seen   (index_seen),
`endif
    .atu_reset    (atu_reset),
    .atu_monitor  (atu_monitor),
    .current_angle(current_angle),
    .direction    (direction),
    .step_error   (step_error),
    .tracking     (tracking)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;
    logic       mon;
    logic       rstn;
    int         hold;
    bit         chk;
    int         angle;
    logic       dir;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic [1:0] ab, logic mon, logic rstn, int hold, bit chk,
                              int angle, logic dir, logic err);
    vec_t v;
    v.ab = ab; v.mon = mon; v.rstn = rstn; v.hold = hold; v.chk = chk;
    v.angle = angle; v.dir = dir; v.err = err;
    return v;
  endfunction

  function automatic logic [1:0] fwd(logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(string name, int angle, logic dir, logic err, logic trk);
    n_vec++;
    if (int'(current_angle) != angle || direction !== dir || step_error !== err ||
        tracking !== trk) begin
      n_fail++;
      $display("FAIL %s: got angle=%0d dir=%b err=%b trk=%b, want angle=%0d dir=%b err=%b trk=%b",
               name, current_angle, direction, step_error, tracking, angle, dir, err, trk);
    end
  endtask

  task automatic check_bit(string name, logic got, logic want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  initial begin
    logic [1:0] ab;
    // Fwd from 01: 00 10 11 01 00 10 11 01 00 -> angles 2..10.
    vecs.push_back(mk(2'b00, 1, 1, 10, 1, 2, 1, 0));
    vecs.push_back(mk(2'b10, 1, 1, 10, 1, 3, 1, 0));
    vecs.push_back(mk(2'b11, 1, 1, 10, 1, 4, 1, 0));
    vecs.push_back(mk(2'b01, 1, 1, 10, 1, 5, 1, 0));
    vecs.push_back(mk(2'b00, 1, 1, 10, 1, 6, 1, 0));
    vecs.push_back(mk(2'b10, 1, 1, 10, 1, 7, 1, 0));
    vecs.push_back(mk(2'b11, 1, 1, 10, 1, 8, 1, 0));
    vecs.push_back(mk(2'b01, 1, 1, 10, 1, 9, 1, 0));
    vecs.push_back(mk(2'b00, 1, 1, 10, 1, 10, 1, 0));
    // Clear, then reverse wrap 0 -> 1005, then forward back through 0 to 1.
    vecs.push_back(mk(2'b00, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2'b00, 1, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 1, 10, 1, 1005, 0, 0));
    vecs.push_back(mk(2'b00, 1, 1, 10, 1, 0, 1, 0));
    vecs.push_back(mk(2'b10, 1, 1, 10, 1, 1, 1, 0));
    // 3-clock glitch on A is rejected.
    vecs.push_back(mk(2'b00, 1, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 1, 1, 10, 1, 1, 1, 0));
    // Both channels change: sticky error, angle held; clear drops it.
    vecs.push_back(mk(2'b01, 1, 1, 10, 1, 1, 1, 1));
    vecs.push_back(mk(2'b01, 1, 1, 10, 1, 1, 1, 1));
    vecs.push_back(mk(2'b01, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 1, 2, 1, 0, 0, 0));
    // Monitor off: five steps are tracked but not counted.
    vecs.push_back(mk(2'b00, 0, 1, 10, 1, 0, 0, 0));
    vecs.push_back(mk(2'b10, 0, 1, 10, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 0, 1, 10, 0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 0, 1, 10, 0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 1, 10, 1, 0, 0, 0));
    vecs.push_back(mk(2'b10, 1, 1, 10, 1, 1, 1, 0));

    n_reset = 1'b0; {enc_a, enc_b} = 2'b11; atu_reset = 1'b1; atu_monitor = 1'b1;
`ifdef ATU_INDEX_EN
    enc_i = 1'b0;
`endif
    tick(3);
    check("reset_state", 0, 0, 0, 0);
    n_reset = 1'b1;
    tick(20);
    check("init_no_count", 0, 0, 0, 1);

    // Latency: raw edge to angle update is FILTER_LEN+3 = 7 clocks.
    {enc_a, enc_b} = 2'b01;
    tick(6);
    check("latency_6", 0, 0, 0, 1);
    tick(1);
    check("latency_7", 1, 1, 0, 1);
    tick(3);

    for (int i = 0; i < vecs.size(); i++) begin
      {enc_a, enc_b} = vecs[i].ab;
      atu_monitor    = vecs[i].mon;
      atu_reset      = vecs[i].rstn;
      tick(vecs[i].hold);
      if (vecs[i].chk) check($sformatf("vec%0d", i), vecs[i].angle, vecs[i].dir, vecs[i].err, 1);
    end
    atu_reset = 1'b1; atu_monitor = 1'b1;
    ab = 2'b10;

`ifdef ATU_INDEX_EN
    for (int i = 0; i < 499; i++) begin
      ab = fwd(ab);
      {enc_a, enc_b} = ab;
      tick(10);
    end
    check("angle_500", 500, 1, 0, 1);
    enc_i = 1'b1;
    tick(2);
    enc_i = 1'b0;
    tick(10);
    check("index_short_ignored", 500, 1, 0, 1);
    check_bit("index_seen_clear", index_seen, 1'b0);
    enc_i = 1'b1;
    tick(10);
    check("index_zero", 0, 1, 0, 1);
    check_bit("index_seen_set", index_seen, 1'b1);
    enc_i = 1'b0;
    tick(10);
    ab = fwd(ab);
    {enc_a, enc_b} = ab;
    tick(10);
    check("post_index_step", 1, 1, 0, 1);
`endif

    // Async reset mid-operation clears immediately and returns to INIT.
    ab = fwd(ab);
    {enc_a, enc_b} = ab;
    tick(10);
    check("pre_async", 2, 1, 0, 1);
    n_reset = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0);
    tick(2);
    n_reset = 1'b1;
    tick(20);
    check("reinit", 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/angle_tracking_unit.md
Name: angle_tracking_unit

Overview:
Quadrature encoder decoder that produces the absolute shaft angle consumed by the servo controller as current_angle. It is the responder side of the controller's atu_reset/atu_monitor/current_angle interface. It synchronises and glitch-filters the raw A/B encoder lines, decodes x4 quadrature steps, and maintains a wrap-around angle counter of COUNTS_PER_REV counts per revolution.

Parameters:
COUNTS_PER_REV, 1006, counts per mechanical revolution; the angle range is 0..COUNTS_PER_REV-1.
ANGLE_W, 12, width of current_angle; must satisfy 2**ANGLE_W >= COUNTS_PER_REV.
FILTER_LEN, 4, number of consecutive equal synchronised samples required to accept a new encoder level (>=1).

Ports:
clk  input  1  system clock.
n_reset  input  1  reset, asynchronous and active-low.
enc_a  input  1  raw encoder channel A, asynchronous to clk.
enc_b  input  1  raw encoder channel B, asynchronous to clk.
atu_reset  input  1  synchronous zero request, active-low; held low clears the angle.
atu_monitor  input  1  count enable; 1 means steps update the angle.
current_angle  output  ANGLE_W  tracked angle, 0..COUNTS_PER_REV-1.
direction  output  1  direction of the last counted step: 1 = increment (A leads B), 0 = decrement.
step_error  output  1  sticky flag: an illegal transition was seen (both channels changed in one filtered update).
tracking  output  1  high while the FSM is in TRACK.

Behaviour:
- Async reset: current_angle=0, direction=0, step_error=0, tracking=0, FSM=INIT, filter outputs=00, filter counters=0.
- Input path, per channel:
  - 2-flop synchroniser.
  - Glitch filter: a counter increments while the synchronised sample differs from the filtered level and clears when they match.
  - On reaching FILTER_LEN, the filtered level takes the new value and the counter clears.
  - Pulses shorter than FILTER_LEN clocks are rejected.
- Latency: a stable raw edge reaches current_angle in exactly FILTER_LEN+3 clocks (7 at default).
- FSM states:
  - INIT: waits until both filters have been stable for FILTER_LEN cycles after reset release. It then loads prev_ab from the filtered AB without counting and goes to TRACK.
  - TRACK: decodes every filtered AB change against prev_ab, then sets prev_ab to AB.
- Decode, with Gray order AB 00->10->11->01->00 as the increment direction:
  - One step forward in that order = INC; one step backward = DEC.
  - No change = NONE.
  - Both bits changing = ERR: step_error<=1, angle unchanged.
- Counting, active only when atu_monitor=1 and atu_reset=1:
  - INC: angle = (angle==COUNTS_PER_REV-1) ? 0 : angle+1, direction<=1.
  - DEC: angle = (angle==0) ? COUNTS_PER_REV-1 : angle-1, direction<=0.
  - Arithmetic is ANGLE_W-bit unsigned; no value >= COUNTS_PER_REV is ever output.
- atu_monitor=0: prev_ab keeps tracking but no count and no direction update, so re-enable causes no jump. ERR still sets step_error.
- atu_reset=0 (synchronous, highest priority):
  - Next edge: current_angle<=0, step_error<=0, direction<=0.
  - prev_ab<=filtered AB, so release produces no count.
  - A step coincident with atu_reset=0 is discarded.
- Async reset mid-operation: all state returns to reset values immediately and the FSM re-enters INIT.
- ERR and atu_reset=0 in the same cycle: clear wins, step_error=0.

Optional Feature:
ATU_INDEX_EN:
- Defined: adds input enc_i (index pulse) through an identical synchroniser and filter, plus output index_seen (sticky, cleared by atu_reset=0 or reset).
- On a filtered rising edge of enc_i in TRACK: current_angle<=0 and index_seen<=1, regardless of atu_monitor.
- An index edge coincident with a step: index wins.
- Undefined: enc_i and index_seen do not exist and behaviour is as above.

Decomposition:
Package atu_pkg contains:
- COUNTS_PER_REV_DEF=1006, ANGLE_W_DEF=12, FILTER_LEN_DEF=4.
- typedef enum {ATU_INIT, ATU_TRACK} atu_state_t.
- typedef enum {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR} step_t.
- Quadrature decode function decode_step(prev_ab, ab) returning step_t.

Sub-module atu_input_filter (synchroniser plus glitch filter, parameter FILTER_LEN, outputs level and stable), instantiated once per channel.

Test Plan:
- Reset, then encoder at AB=11, then 20 idle clocks -> tracking=1, current_angle=0, step_error=0 (no spurious count from INIT).
- 10 forward Gray steps (00->10->11->01...), each held 10 clocks -> current_angle=10, direction=1; first update appears exactly 7 clocks after the first raw edge.
- From angle 0, one reverse step -> current_angle=1005, direction=0. Then 2 forward steps -> current_angle=1.
- 3-clock glitch on enc_a -> no change in current_angle. Direct AB 00->11 held 10 clocks -> step_error=1, angle unchanged. Then atu_reset low 1 clock -> step_error=0, current_angle=0.
- atu_monitor=0 during 5 forward steps, then atu_monitor=1 and 1 more step -> current_angle increases by exactly 1.
- With ATU_INDEX_EN at angle 500: enc_i pulse held 10 clocks -> current_angle=0, index_seen=1. A 2-clock enc_i pulse -> ignored.
